seven_seg_mux_driver: RTL and testbench
=======================================

SEVEN_SEG_MUX_DRIVER -- requirements
Module: seven_seg_mux_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 4, meaning clock cycles per digit slot; legal range is 2 or greater.
REQ-002 Port CLK, input, width 1, meaning the single clock; all state is updated on the rising edge.
REQ-003 Port Clear_b, input, width 1, meaning synchronous active-low reset.
REQ-004 Port AO, input, width 4, meaning BCD ones digit from the upstream two-digit counter.
REQ-005 Port BO, input, width 4, meaning BCD tens digit from the upstream two-digit counter.
REQ-006 Port carryIn, input, width 1, meaning a one-cycle overflow pulse from the counter carryOut.
REQ-007 Port enable, input, width 1, meaning display on (1) or blanked and frozen (0).
REQ-008 Port ovf_clr, input, width 1, meaning a clear pulse for the sticky overflow flag.
REQ-009 Port seg, output, width 7, meaning segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 Port an, output, width 2, meaning digit anodes, active-low, registered; an[0] drives the ones digit and an[1] the tens digit.
REQ-011 Port dp, output, width 1, meaning the decimal point, active-low, registered.

Function
REQ-012 The block SHALL keep these internal state elements:
- prescaler, a count of 0..REFRESH_DIV-1;
- sel, the active digit (0 = ones, 1 = tens);
- snapA and snapB, the snapshot registers;
- ovf, the sticky overflow flag.
REQ-013 Prescaler and sel, when enable=1:
- prescaler SHALL increment each cycle;
- at REFRESH_DIV-1 it SHALL wrap to 0 and sel SHALL toggle.
REQ-014 Frame boundary: on the edge where the prescaler wraps with sel=1 (sel goes 1 to 0), snapA<=AO and snapB<=BO. AO/BO changes at any other time SHALL NOT affect the display until the next frame boundary.
REQ-015 Output registers, when enable=1, update every cycle from the current sel and snapshots, giving a latency of 1 cycle:
- sel=0: an=2'b10, seg=decode(snapA), dp=1;
- sel=1: an=2'b01, seg=decode(snapB), dp=~ovf.
REQ-016 Decode, active-low:
- 0 = 1000000
- 1 = 1111001
- 2 = 0100100
- 3 = 0110000
- 4 = 0011001
- 5 = 0010010
- 6 = 0000010
- 7 = 1111000
- 8 = 0000000
- 9 = 0010000
- 10-15 (invalid BCD) = 0111111, a dash.
REQ-017 When enable=0:
- prescaler, sel and the snapshots SHALL hold;
- the output registers SHALL load an=2'b11, seg=7'b1111111, dp=1 on the next edge.
REQ-018 When enable returns to 1, counting SHALL resume from the held prescaler/sel values with no re-snapshot except at a frame boundary.
REQ-019 ovf SHALL set on any edge with carryIn=1, regardless of enable.
REQ-020 ovf SHALL clear on an edge with ovf_clr=1 and carryIn=0; when both are 1, the set wins.
REQ-021 carryIn pulses SHALL NOT be lost while enable=0.

Reset
REQ-022 On an edge with Clear_b=0, the block SHALL load: prescaler=REFRESH_DIV-1, sel=1, snapA=0, snapB=0, ovf=0, an=2'b11, seg=7'b1111111, dp=1.
REQ-023 Reset SHALL take priority over enable, carryIn and ovf_clr, and SHALL abort a frame in progress.
REQ-024 Because reset leaves the prescaler at its wrap point with sel=1, the first enabled edge after reset SHALL be a frame boundary: snapshot taken and sel=0. The first lit output (ones digit) SHALL appear one edge later.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN controls tens-digit blanking.
- Defined: when sel=1 and snapB==0, seg SHALL be 7'b1111111; an and dp SHALL behave per REQ-015.
- Undefined: the tens digit 0 SHALL display as 1000000.

Verification (REFRESH_DIV=4)
REQ-026 Reset: hold Clear_b=0 for 3 cycles with enable=1 and carryIn=1 -> an=11, seg=1111111, dp=1 throughout, and ovf=0 after release (with carryIn=0).
REQ-027 Display 33: AO=BO=3, enable=1 after reset -> repeating 4 cycles an=10, seg=0110000 then 4 cycles an=01, seg=0110000, dp=1.
REQ-028 Mid-frame change: change AO from 3 to 7 during the tens slot -> the ones slot shows 7 (1111000) starting in the next frame; change it during the ones slot -> the old value persists until the frame ends.
REQ-029 Invalid BCD and enable=0:
- AO=4'hC -> ones slot seg=0111111;
- drop enable for 6 cycles -> an=11 one edge later, and the slot phase resumes where it stopped.
REQ-030 Overflow:
- one-cycle carryIn pulse -> dp=0 in every tens slot thereafter;
- ovf_clr pulse -> dp=1;
- carryIn and ovf_clr asserted together -> dp stays 0.
REQ-031 Leading-zero blanking: BO=0, AO=5 -> tens slot seg=1111111 with the macro defined and 1000000 without; the ones slot is 0010010 in both builds.

Source files
------------

// File: rtl/seven_seg_mux_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_mux_driver
//
// Time-multiplexes a two-digit BCD value onto a common two-anode seven-segment
// display. Each digit slot lasts REFRESH_DIV clock cycles. Both digits are
// snapshotted together at the start of each frame, so the two displayed
// digits always come from the same counter value. A sticky overflow flag
// lights the decimal point of the tens digit.
//
// Parameters:
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, a tens digit of 0 is blanked
//
// Ports:
//   CLK      clock, rising edge
//   Clear_b  synchronous active-low reset
//   AO       BCD ones digit from the upstream counter
//   BO       BCD tens digit from the upstream counter
//   carryIn  one-cycle overflow pulse, sets the sticky flag
//   enable   1 = display running, 0 = blanked and frozen
//   ovf_clr  clears the sticky overflow flag (carryIn wins)
//   seg      segments {g,f,e,d,c,b,a}, active-low, registered
//   an       anodes, an[0] = ones, an[1] = tens, active-low, registered
//   dp       decimal point, active-low, registered
// ---------------------------------------------------------------------------
module seven_seg_mux_driver #(
  parameter int REFRESH_DIV = 4
) (
  input  logic       CLK,
  input  logic       Clear_b,
  input  logic [3:0] AO,
  input  logic [3:0] BO,
  input  logic       carryIn,
  input  logic       enable,
  input  logic       ovf_clr,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp
);

  localparam int            PW      = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [1:0] AN_OFF  = 2'b11;

  logic [PW-1:0] prescaler;
  logic          sel;
  logic [3:0]    snap_a;
  logic [3:0]    snap_b;
  logic          ovf;
  logic          wrap;

  logic [6:0]    seg_p0;
  logic [1:0]    an_p0;
  logic          dp_p0;

  // Active-low BCD decode; codes 10-15 show a dash (segment g only).
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign wrap = (prescaler == PRE_MAX);

  // Slot timing and frame snapshot. Reset parks the prescaler at its wrap
  // point with sel=1, so the first enabled edge is a frame boundary.
  always_ff @(posedge CLK) begin
    if (!Clear_b) begin
      prescaler <= PRE_MAX;
      sel       <= 1'b1;
      snap_a    <= 4'd0;
      snap_b    <= 4'd0;
    end else if (enable) begin
      if (wrap) begin
        prescaler <= '0;
        sel       <= ~sel;
        if (sel) begin
          snap_a <= AO;
          snap_b <= BO;
        end
      end else begin
        prescaler <= prescaler + PRE_ONE;
      end
    end
  end

  // Sticky overflow runs regardless of enable so no carry is ever missed.
  always_ff @(posedge CLK) begin
    if (!Clear_b) begin
      ovf <= 1'b0;
    end else if (carryIn) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // Stage p0: select the active digit and decode it.
  always_comb begin
    seg_p0 = SEG_OFF;
    an_p0  = AN_OFF;
    dp_p0  = 1'b1;
    if (enable) begin
      if (!sel) begin
        an_p0  = 2'b10;
        seg_p0 = decode(snap_a);
      end else begin
        an_p0  = 2'b01;
        seg_p0 = decode(snap_b);
`ifdef LEADING_ZERO_BLANK_EN
        if (snap_b == 4'd0) begin
          seg_p0 = SEG_OFF;
        end
`endif
        dp_p0  = ~ovf;
      end
    end
  end

  // Stage p1: registered pad drivers.
  always_ff @(posedge CLK) begin
    if (!Clear_b) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
      dp  <= 1'b1;
    end else begin
      seg <= seg_p0;
      an  <= an_p0;
      dp  <= dp_p0;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_mux_driver
//
// Bench for seven_seg_mux_driver with REFRESH_DIV=4. A behavioural model
// predicts the registered outputs for every clock; predictions are queued
// when inputs are applied and compared after the edge. Directed scenarios
// add fixed-value checks on top of the model. Define LEADING_ZERO_BLANK_EN
// for both bench and design to test the blanking build.
// ---------------------------------------------------------------------------
module tb_seven_seg_mux_driver;

  localparam int RD = 4;

  logic       CLK;
  logic       Clear_b;
  logic [3:0] AO;
  logic [3:0] BO;
  logic       carryIn;
  logic       enable;
  logic       ovf_clr;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;

  seven_seg_mux_driver #(.REFRESH_DIV(RD)) dut (
    .CLK     (CLK),
    .Clear_b (Clear_b),
    .AO      (AO),
    .BO      (BO),
    .carryIn (carryIn),
    .enable  (enable),
    .ovf_clr (ovf_clr),
    .seg     (seg),
    .an      (an),
    .dp      (dp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] exp_q[$];

  // Model state
  int         m_pre;
  logic       m_sel;
  logic [3:0] m_a;
  logic [3:0] m_b;
  logic       m_ovf;

  logic [6:0] seg_tab [16];

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] TENS_ZERO = 7'b1111111;
`else
  localparam logic [6:0] TENS_ZERO = 7'b1000000;
`endif

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Predict, advance the model, clock the DUT, then compare.
  task automatic cycle();
    logic [6:0] e_seg;
    logic [1:0] e_an;
    logic       e_dp;
    logic [9:0] e;
    e_seg = 7'h7f;
    e_an  = 2'b11;
    e_dp  = 1'b1;
    if (Clear_b && enable) begin
      if (!m_sel) begin
        e_an  = 2'b10;
        e_seg = seg_tab[m_a];
      end else begin
        e_an  = 2'b01;
        e_seg = (m_b == 4'd0) ? TENS_ZERO : seg_tab[m_b];
        e_dp  = ~m_ovf;
      end
    end
    exp_q.push_back({e_an, e_seg, e_dp});

    if (!Clear_b) begin
      m_pre = RD - 1;
      m_sel = 1'b1;
      m_a   = 4'd0;
      m_b   = 4'd0;
      m_ovf = 1'b0;
    end else begin
      if (enable) begin
        if (m_pre == RD - 1) begin
          m_pre = 0;
          if (m_sel) begin
            m_a = AO;
            m_b = BO;
          end
          m_sel = ~m_sel;
        end else begin
          m_pre = m_pre + 1;
        end
      end
      if (carryIn)      m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end

    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    check("an_seg_dp", {6'd0, an, seg, dp}, {6'd0, e});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;
    m_pre = 0; m_sel = 1'b0; m_a = 4'd0; m_b = 4'd0; m_ovf = 1'b0;

    // Reset held 3 cycles against enable and carryIn
    Clear_b = 1'b0; enable = 1'b1; carryIn = 1'b1; ovf_clr = 1'b0;
    AO = 4'd3; BO = 4'd3;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rst_an", {14'd0, an}, 16'h3);
      check("rst_seg", {9'd0, seg}, 16'h7f);
      check("rst_dp", {15'd0, dp}, 16'h1);
    end
    Clear_b = 1'b1; carryIn = 1'b0;

    // Edge 1: frame boundary, output still shows the reset tens snapshot
    cycle();
    check("first_tens_an", {14'd0, an}, 16'h1);
    check("ovf_after_rst", {15'd0, dp}, 16'h1);
    // Edge 2: ones digit lit
    cycle();
    check("d33_ones_an", {14'd0, an}, 16'h2);
    check("d33_ones_seg", {9'd0, seg}, 16'h30);
    run(4); // edge 6: first tens slot of a real frame
    check("d33_tens_an", {14'd0, an}, 16'h1);
    check("d33_tens_seg", {9'd0, seg}, 16'h30);
    check("d33_tens_dp", {15'd0, dp}, 16'h1);

    // Change during tens slot: picked up at the next frame boundary (edge 9)
    run(1);
    AO = 4'd7;
    run(3); // edge 10
    check("mid_tens_an", {14'd0, an}, 16'h2);
    check("mid_tens_seg", {9'd0, seg}, 16'h78);
    // Change during ones slot: old value persists
    AO = 4'd3;
    run(3); // edge 13, last ones cycle
    check("mid_ones_hold", {9'd0, seg}, 16'h78);
    run(5); // edge 18, next frame ones slot
    check("mid_ones_new", {9'd0, seg}, 16'h30);

    // Invalid BCD
    AO = 4'hC;
    run(8); // edge 26
    check("dash_an", {14'd0, an}, 16'h2);
    check("dash_seg", {9'd0, seg}, 16'h3f);

    // Enable drop for 6 cycles
    enable = 1'b0;
    run(1);
    check("dis_an", {14'd0, an}, 16'h3);
    check("dis_seg", {9'd0, seg}, 16'h7f);
    run(5);
    enable = 1'b1;
    run(3); // edges 33-35 ones slot resumes
    check("resume_ones", {14'd0, an}, 16'h2);
    run(1); // edge 36
    check("resume_tens", {14'd0, an}, 16'h1);

    // Overflow; AO=5/BO=0 snapshot at edge 39
    AO = 4'd5; BO = 4'd0;
    carryIn = 1'b1;
    run(1);
    carryIn = 1'b0;
    run(1); // edge 38
    check("ovf_dp", {15'd0, dp}, 16'h0);
    run(2); // edge 40
    check("lzb_ones_seg", {9'd0, seg}, 16'h12);
    check("ones_dp", {15'd0, dp}, 16'h1);
    run(4); // edge 44
    check("lzb_tens_seg", {9'd0, seg}, {9'd0, TENS_ZERO});
    check("ovf_sticky", {15'd0, dp}, 16'h0);
    ovf_clr = 1'b1;
    run(1);
    ovf_clr = 1'b0;
    run(1); // edge 46
    check("ovf_cleared", {15'd0, dp}, 16'h1);
    carryIn = 1'b1; ovf_clr = 1'b1;
    run(1);
    carryIn = 1'b0; ovf_clr = 1'b0;
    run(5); // edge 52
    check("ovf_set_wins", {15'd0, dp}, 16'h0);

    // carryIn while disabled is retained
    enable = 1'b0; ovf_clr = 1'b1;
    run(1);
    ovf_clr = 1'b0; carryIn = 1'b1;
    run(1);
    carryIn = 1'b0;
    run(2);
    enable = 1'b1;
    run(1);
    check("dis_carry_an", {14'd0, an}, 16'h1);
    check("dis_carry_dp", {15'd0, dp}, 16'h0);

    // Reset mid-frame clears ovf and restarts the frame
    Clear_b = 1'b0;
    run(1);
    check("rst2_an", {14'd0, an}, 16'h3);
    Clear_b = 1'b1;
    run(1);
    check("rst2_dp", {15'd0, dp}, 16'h1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      AO      = 4'($urandom_range(0, 15));
      BO      = 4'($urandom_range(0, 15));
      carryIn = ($urandom_range(0, 19) == 0);
      ovf_clr = ($urandom_range(0, 14) == 0);
      enable  = ($urandom_range(0, 9) != 0);
      Clear_b = ($urandom_range(0, 49) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
